systolic_matmul_engine: RTL and testbench

//  Parametrised output-stationary systolic matrix multiplier, C = A(NxK) * B(KxM) [+ Cin].

---
 rtl/matmul_pkg.sv | 41 ++++
 rtl/matmul_pe_sat.sv | 76 +++++++
 rtl/systolic_matmul_engine.sv | 174 +++++++++++++++++
 tb/tb_systolic_matmul_engine.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared definitions for the systolic matrix engine: FSM states, sizing and
// packing helpers, saturation bounds.
package matmul_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_FEED  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // A and C are row-major, B is column-major.
   function automatic int a_idx(input int r, input int c, input int max_dim);
      return r * max_dim + c;
   endfunction

   function automatic int b_idx(input int r, input int c, input int max_dim);
      return c * max_dim + r;
   endfunction

   function automatic int c_idx(input int r, input int c, input int max_dim);
      return r * max_dim + c;
   endfunction

   function automatic int sat_max(input int bw);
      return (1 << (bw - 1)) - 1;
   endfunction

   function automatic int sat_min(input int bw);
      return -(1 << (bw - 1));
   endfunction

endpackage

// File: rtl/matmul_pe_sat.sv
// One processing element: preloadable accumulator, signed MAC with saturate or
// wrap, sticky overflow flag, and registered A/B forwarding to its neighbours.
module matmul_pe_sat
   import matmul_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int BUS_WIDTH  = 16
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         i_load,
   input  logic                         i_en,
   input  logic                         i_sat,
   input  logic signed [BUS_WIDTH-1:0]  i_preload,
   input  logic signed [DATA_WIDTH-1:0] i_a,
   input  logic signed [DATA_WIDTH-1:0] i_b,
   output logic signed [DATA_WIDTH-1:0] o_a,
   output logic signed [DATA_WIDTH-1:0] o_b,
   output logic signed [BUS_WIDTH-1:0]  o_acc,
   output logic                         o_flag
);

   localparam logic signed [BUS_WIDTH-1:0] SAT_HI = BUS_WIDTH'(sat_max(BUS_WIDTH));
   localparam logic signed [BUS_WIDTH-1:0] SAT_LO = BUS_WIDTH'(sat_min(BUS_WIDTH));

   logic signed [BUS_WIDTH-1:0]    r_acc;
   logic                           r_flag;
   logic signed [DATA_WIDTH-1:0]   r_a;
   logic signed [DATA_WIDTH-1:0]   r_b;
   logic signed [2*DATA_WIDTH-1:0] w_prod;
   logic        [BUS_WIDTH:0]      w_sum;
   logic                           w_ovf;
   logic signed [BUS_WIDTH-1:0]    w_next;

   // One guard bit: overflow shows as disagreement between the top two sum bits.
   assign w_prod = i_a * i_b;
   assign w_sum  = {r_acc[BUS_WIDTH-1], r_acc}
                 + {{(BUS_WIDTH+1-2*DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};
   assign w_ovf  = w_sum[BUS_WIDTH] ^ w_sum[BUS_WIDTH-1];

   // Clamp toward the sign of the true sum, or keep the low bits.
   always_comb begin
      w_next = w_sum[BUS_WIDTH-1:0];
      if (w_ovf && i_sat) begin
         w_next = w_sum[BUS_WIDTH] ? SAT_LO : SAT_HI;
      end else begin
         w_next = w_sum[BUS_WIDTH-1:0];
      end
   end

   // Accumulator, sticky flag and forwarding registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_acc  <= '0;
         r_flag <= 1'b0;
         r_a    <= '0;
         r_b    <= '0;
      end else if (i_load) begin
         r_acc  <= i_preload;
         r_flag <= 1'b0;
         r_a    <= '0;
         r_b    <= '0;
      end else if (i_en) begin
         r_acc  <= w_next;
         r_flag <= r_flag | w_ovf;
         r_a    <= i_a;
         r_b    <= i_b;
      end
   end

   assign o_a    = r_a;
   assign o_b    = r_b;
   assign o_acc  = r_acc;
   assign o_flag = r_flag;

endmodule

// File: rtl/systolic_matmul_engine.sv
// Output-stationary systolic multiplier C = A*B [+ Cin]: FSM, skewed feeders,
// MAX_DIM x MAX_DIM PE grid and a result register that holds between runs.
module systolic_matmul_engine
   import matmul_pkg::*;
#(
   parameter  int DATA_WIDTH = 8,
   parameter  int BUS_WIDTH  = 16,
   parameter  int MAX_DIM    = 4,
   localparam int DIM_W      = clog2(MAX_DIM)
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic                                  start_i,
   input  logic [DIM_W-1:0]                      n_dim_i,
   input  logic [DIM_W-1:0]                      k_dim_i,
   input  logic [DIM_W-1:0]                      m_dim_i,
   input  logic                                  acc_mode_i,
   input  logic                                  sat_mode_i,
   input  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0] a_matrix_i,
   input  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0] b_matrix_i,
   input  logic [MAX_DIM*MAX_DIM*BUS_WIDTH-1:0]  c_matrix_i,
   output logic                                  busy_o,
   output logic                                  done_o,
   output logic [MAX_DIM*MAX_DIM*BUS_WIDTH-1:0]  c_matrix_o,
   output logic [MAX_DIM*MAX_DIM-1:0]            flags_o
);

   localparam int NE  = MAX_DIM * MAX_DIM;
   localparam int T_W = clog2(3 * MAX_DIM) + 1;

   state_e                       r_state, w_state_nxt;
   logic [DIM_W-1:0]             r_nd, r_kd, r_md;
   logic                         r_acc_mode, r_sat_mode;
   logic [NE*DATA_WIDTH-1:0]     r_a, r_b;
   logic [NE*BUS_WIDTH-1:0]      r_cin;
   logic [T_W-1:0]               r_t, w_t_last;
   logic                         r_busy, r_done;
   logic [NE*BUS_WIDTH-1:0]      r_c;
   logic [NE-1:0]                r_flags;
   logic                         w_load, w_feed;
   logic signed [DATA_WIDTH-1:0] w_row [MAX_DIM];
   logic signed [DATA_WIDTH-1:0] w_col [MAX_DIM];
   logic signed [DATA_WIDTH-1:0] w_a   [MAX_DIM][MAX_DIM];
   logic signed [DATA_WIDTH-1:0] w_b   [MAX_DIM][MAX_DIM];
   logic [NE*BUS_WIDTH-1:0]      w_acc_flat;
   logic [NE-1:0]                w_flag_flat;

   // The last MAC reaches the far-corner PE at t = (Nd-1)+(Kd-1)+(Md-1).
   assign w_t_last = T_W'(r_nd) + T_W'(r_kd) + T_W'(r_md);
   assign w_load   = (r_state == ST_LOAD);
   assign w_feed   = (r_state == ST_FEED);

   // FSM state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   // FSM next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (start_i) w_state_nxt = ST_LOAD; else w_state_nxt = ST_IDLE;
         ST_LOAD:  w_state_nxt = ST_FEED;
         ST_FEED:  if (r_t == w_t_last) w_state_nxt = ST_DRAIN; else w_state_nxt = ST_FEED;
         ST_DRAIN: w_state_nxt = ST_DONE;
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Operand capture at start and the feed counter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_nd <= '0; r_kd <= '0; r_md <= '0;
         r_acc_mode <= 1'b0; r_sat_mode <= 1'b0;
         r_a <= '0; r_b <= '0; r_cin <= '0;
         r_t <= '0;
      end else begin
         if (r_state == ST_IDLE && start_i) begin
            r_nd <= n_dim_i; r_kd <= k_dim_i; r_md <= m_dim_i;
            r_acc_mode <= acc_mode_i; r_sat_mode <= sat_mode_i;
            r_a <= a_matrix_i; r_b <= b_matrix_i; r_cin <= c_matrix_i;
         end
         if (w_load)      r_t <= '0;
         else if (w_feed) r_t <= r_t + T_W'(1);
      end
   end

   // Skewed edge feeders: row i lags by i cycles, column j by j cycles.
   always_comb begin
      int k;
      k = 0;
      for (int i = 0; i < MAX_DIM; i++) begin
         w_row[i] = '0;
         w_col[i] = '0;
         k = int'(r_t) - i;
         if (k >= 0 && k <= int'(r_kd) && i <= int'(r_nd)) begin
            w_row[i] = r_a[a_idx(i, k, MAX_DIM)*DATA_WIDTH +: DATA_WIDTH];
         end else begin
            w_row[i] = '0;
         end
         if (k >= 0 && k <= int'(r_kd) && i <= int'(r_md)) begin
            w_col[i] = r_b[b_idx(k, i, MAX_DIM)*DATA_WIDTH +: DATA_WIDTH];
         end else begin
            w_col[i] = '0;
         end
      end
   end

   for (genvar gi = 0; gi < MAX_DIM; gi++) begin : g_row
      for (genvar gj = 0; gj < MAX_DIM; gj++) begin : g_col
         logic signed [DATA_WIDTH-1:0] w_a_in, w_b_in;
         logic signed [BUS_WIDTH-1:0]  w_pre;

         if (gj == 0) begin : g_a_edge
            assign w_a_in = w_row[gi];
         end else begin : g_a_int
            assign w_a_in = w_a[gi][gj-1];
         end
         if (gi == 0) begin : g_b_edge
            assign w_b_in = w_col[gj];
         end else begin : g_b_int
            assign w_b_in = w_b[gi-1][gj];
         end

         // Unused elements preload 0 so they read back as 0 even in accumulate mode.
         assign w_pre = (r_acc_mode && DIM_W'(gi) <= r_nd && DIM_W'(gj) <= r_md)
                      ? r_cin[c_idx(gi, gj, MAX_DIM)*BUS_WIDTH +: BUS_WIDTH] : '0;

         matmul_pe_sat #(
            .DATA_WIDTH (DATA_WIDTH),
            .BUS_WIDTH  (BUS_WIDTH)
         ) u_pe (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .i_load    (w_load),
            .i_en      (w_feed),
            .i_sat     (r_sat_mode),
            .i_preload (w_pre),
            .i_a       (w_a_in),
            .i_b       (w_b_in),
            .o_a       (w_a[gi][gj]),
            .o_b       (w_b[gi][gj]),
            .o_acc     (w_acc_flat[c_idx(gi, gj, MAX_DIM)*BUS_WIDTH +: BUS_WIDTH]),
            .o_flag    (w_flag_flat[c_idx(gi, gj, MAX_DIM)])
         );
      end
   end

   // Registered handshake and result; the result only moves in DONE.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_c     <= '0;
         r_flags <= '0;
      end else begin
         r_busy <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_FEED) ||
                   (w_state_nxt == ST_DRAIN);
         r_done <= (r_state == ST_DONE);
         if (r_state == ST_DONE) begin
            r_c     <= w_acc_flat;
            r_flags <= w_flag_flat;
         end
      end
   end

   assign busy_o     = r_busy;
   assign done_o     = r_done;
   assign c_matrix_o = r_c;
   assign flags_o    = r_flags;

endmodule

// File: tb/tb_systolic_matmul_engine.sv
// Self-checking bench for systolic_matmul_engine against a plain-arithmetic
// matrix model with explicit saturate/wrap accumulation in k order.
module tb_systolic_matmul_engine;

   localparam int DW = 8;
   localparam int BW = 16;
   localparam int MD = 4;
   localparam int NE = MD * MD;

   logic                 clk_i = 1'b0;
   logic                 rst_ni = 1'b1;
   logic                 start_i = 1'b0;
   logic [1:0]           n_dim_i = '0, k_dim_i = '0, m_dim_i = '0;
   logic                 acc_mode_i = 1'b0, sat_mode_i = 1'b0;
   logic [NE*DW-1:0]     a_matrix_i = '0, b_matrix_i = '0;
   logic [NE*BW-1:0]     c_matrix_i = '0;
   logic                 busy_o, done_o;
   logic [NE*BW-1:0]     c_matrix_o;
   logic [NE-1:0]        flags_o;

   int vectors = 0;
   int miscompares = 0;
   int A [MD][MD];
   int B [MD][MD];
   int CI[MD][MD];
   logic [NE*BW-1:0] exp_c, held_c;
   logic [NE-1:0]    exp_f, held_f;

   systolic_matmul_engine #(.DATA_WIDTH(DW), .BUS_WIDTH(BW), .MAX_DIM(MD)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
      .n_dim_i(n_dim_i), .k_dim_i(k_dim_i), .m_dim_i(m_dim_i),
      .acc_mode_i(acc_mode_i), .sat_mode_i(sat_mode_i),
      .a_matrix_i(a_matrix_i), .b_matrix_i(b_matrix_i), .c_matrix_i(c_matrix_i),
      .busy_o(busy_o), .done_o(done_o), .c_matrix_o(c_matrix_o), .flags_o(flags_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic int rnd8();
      return int'($urandom_range(0, 255)) - 128;
   endfunction

   task automatic fill_random();
      for (int r = 0; r < MD; r++)
         for (int c = 0; c < MD; c++) begin
            A[r][c]  = rnd8();
            B[r][c]  = rnd8();
            CI[r][c] = int'($urandom_range(0, 65535)) - 32768;
         end
   endtask

   task automatic pack();
      int v;
      for (int r = 0; r < MD; r++)
         for (int c = 0; c < MD; c++) begin
            v = A[r][c];  a_matrix_i[(r*MD+c)*DW +: DW] = v[DW-1:0];
            v = B[r][c];  b_matrix_i[(c*MD+r)*DW +: DW] = v[DW-1:0];
            v = CI[r][c]; c_matrix_i[(r*MD+c)*BW +: BW] = v[BW-1:0];
         end
   endtask

   // Reference: C[r][c] = (acc ? Cin : 0) + sum_k A[r][k]*B[k][c], range-limited per step.
   task automatic model(input int n, input int k, input int m, input bit acc, input bit sat);
      int s, a;
      bit f;
      exp_c = '0;
      exp_f = '0;
      for (int r = 0; r < n; r++)
         for (int c = 0; c < m; c++) begin
            a = acc ? CI[r][c] : 0;
            f = 1'b0;
            for (int kk = 0; kk < k; kk++) begin
               s = a + A[r][kk] * B[kk][c];
               if (s > 32767 || s < -32768) begin
                  f = 1'b1;
                  if (sat) a = (s > 0) ? 32767 : -32768;
                  else     a = int'(shortint'(s));
               end else begin
                  a = s;
               end
            end
            exp_c[(r*MD+c)*BW +: BW] = a[BW-1:0];
            exp_f[r*MD+c] = f;
         end
   endtask

   task automatic run(input string nm, input int n, input int k, input int m,
                      input bit acc, input bit sat, input bit poke);
      int s, lat, busy_cnt;
      bit seen;
      s = n + k + m;
      lat = 0;
      busy_cnt = 0;
      seen = 1'b0;
      model(n, k, m, acc, sat);
      pack();
      n_dim_i = 2'(n - 1); k_dim_i = 2'(k - 1); m_dim_i = 2'(m - 1);
      acc_mode_i = acc; sat_mode_i = sat;
      start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      if (busy_o) busy_cnt++;
      for (int e = 1; e <= 60 && !seen; e++) begin
         if (poke && e == 3) begin start_i = 1'b1; a_matrix_i = '1; end
         if (poke && e == 4) start_i = 1'b0;
         @(posedge clk_i); #1;
         if (done_o) begin
            seen = 1'b1;
            lat = e;
         end else if (busy_o) begin
            busy_cnt++;
         end
         if (e == 2) begin
            vectors++;
            if (c_matrix_o !== held_c || flags_o !== held_f) begin
               miscompares++;
               $display("FAIL %s hold: got c=%h f=%h want c=%h f=%h", nm, c_matrix_o, flags_o, held_c, held_f);
            end
         end
      end
      vectors++;
      if (!seen) begin
         miscompares++;
         $display("FAIL %s timeout: done_o never seen, want at edge %0d", nm, s + 1);
      end else begin
         if (lat != s + 1) begin
            miscompares++;
            $display("FAIL %s latency: got %0d want %0d", nm, lat, s + 1);
         end
         vectors++;
         if (busy_cnt != s) begin
            miscompares++;
            $display("FAIL %s busy_cycles: got %0d want %0d", nm, busy_cnt, s);
         end
         for (int i = 0; i < NE; i++) begin
            vectors++;
            if (c_matrix_o[i*BW +: BW] !== exp_c[i*BW +: BW]) begin
               miscompares++;
               $display("FAIL %s c[%0d][%0d]: got %0d want %0d", nm, i / MD, i % MD,
                        $signed(c_matrix_o[i*BW +: BW]), $signed(exp_c[i*BW +: BW]));
            end
         end
         vectors++;
         if (flags_o !== exp_f) begin
            miscompares++;
            $display("FAIL %s flags: got %h want %h", nm, flags_o, exp_f);
         end
         @(posedge clk_i); #1;
         vectors++;
         if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL %s pulse_end: got done=%b busy=%b want 0 0", nm, done_o, busy_o);
         end
      end
      held_c = exp_c;
      held_f = exp_f;
   endtask

   task automatic test_reset();
      #2 rst_ni = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      vectors++;
      if (busy_o !== 1'b0 || done_o !== 1'b0 || c_matrix_o !== '0 || flags_o !== '0) begin
         miscompares++;
         $display("FAIL reset: got busy=%b done=%b c=%h f=%h want all 0", busy_o, done_o, c_matrix_o, flags_o);
      end
      @(negedge clk_i) rst_ni = 1'b1;
      held_c = '0;
      held_f = '0;
   endtask

   task automatic test_identity();
      fill_random();
      A[0][0] = 1; A[0][1] = 0; A[1][0] = 0; A[1][1] = 1;
      B[0][0] = 3; B[0][1] = -4; B[1][0] = 5; B[1][1] = 6;
      run("identity", 2, 2, 2, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_saturate_wrap();
      for (int r = 0; r < MD; r++)
         for (int c = 0; c < MD; c++) begin A[r][c] = 127; B[r][c] = 127; end
      run("all127_sat", 4, 4, 4, 1'b0, 1'b1, 1'b0);
      run("all127_wrap", 4, 4, 4, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_accumulate();
      fill_random();
      for (int r = 0; r < MD; r++)
         for (int c = 0; c < MD; c++) CI[r][c] = 100;
      A[0][0] = 1; A[1][0] = 2; A[2][0] = 3;
      B[0][0] = 4; B[0][1] = -5;
      run("acc_3x1x2", 3, 1, 2, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_flag_clear();
      for (int r = 0; r < MD; r++)
         for (int c = 0; c < MD; c++) begin A[r][c] = -128; B[r][c] = -128; end
      run("neg128_sat", 4, 4, 4, 1'b0, 1'b1, 1'b0);
      for (int r = 0; r < MD; r++)
         for (int c = 0; c < MD; c++) begin A[r][c] = 0; B[r][c] = 0; end
      run("zero_rerun", 4, 4, 4, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_start_ignored();
      int extra;
      extra = 0;
      fill_random();
      run("start_in_feed", 3, 4, 2, 1'b1, 1'b1, 1'b1);
      repeat (12) begin
         @(posedge clk_i); #1;
         if (done_o) extra++;
      end
      vectors++;
      if (extra != 0) begin
         miscompares++;
         $display("FAIL start_in_feed extra_done: got %0d pulses want 0", extra);
      end
   endtask

   task automatic test_reset_midrun();
      int pulses;
      pulses = 0;
      fill_random();
      pack();
      n_dim_i = 2'd3; k_dim_i = 2'd3; m_dim_i = 2'd3;
      acc_mode_i = 1'b1; sat_mode_i = 1'b0;
      start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1 rst_ni = 1'b0;
      #1;
      vectors++;
      if (busy_o !== 1'b0 || done_o !== 1'b0 || c_matrix_o !== '0 || flags_o !== '0) begin
         miscompares++;
         $display("FAIL reset_midrun: got busy=%b done=%b c=%h f=%h want all 0", busy_o, done_o, c_matrix_o, flags_o);
      end
      @(negedge clk_i) rst_ni = 1'b1;
      repeat (20) begin
         @(posedge clk_i); #1;
         if (done_o) pulses++;
      end
      vectors++;
      if (pulses != 0) begin
         miscompares++;
         $display("FAIL reset_midrun no_done: got %0d pulses want 0", pulses);
      end
      held_c = '0;
      held_f = '0;
      fill_random();
      run("after_reset", 4, 3, 4, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      int n, k, m;
      for (int i = 0; i < 8; i++) begin
         fill_random();
         n = int'($urandom_range(1, 4));
         k = int'($urandom_range(1, 4));
         m = int'($urandom_range(1, 4));
         run($sformatf("rand%0d", i), n, k, m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      end
   endtask

   task automatic test_back_to_back();
      fill_random();
      run("b2b_first", 2, 3, 4, 1'b0, 1'b1, 1'b0);
      fill_random();
      run("b2b_second", 4, 1, 3, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_identity();
      test_saturate_wrap();
      test_accumulate();
      test_flag_clear();
      test_start_ignored();
      test_reset_midrun();
      test_random();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
